ula_seq_flags: RTL
==================

// Module: ula_seq_flags
// PURPOSE
//  Sequential, parametrised ALU: successor to the combinational AR/LO ALU pair.
//  Merges arithmetic, logic, shift and iterative multiply into one unit.
//  Registered result and O/C/S/Z flags, valid/ready handshake, carry-chained ops.
//  Sits between the register file read stage and the write-back/flag register.
// PARAMETERS
//  BITS    8  operand/result width (>=2)
//  MUL_EN  1  1 = MUL opcode implemented (shift-add, BITS cycles); 0 = MUL is undefined
// PORTS
//  CLK        in   1        clock, all state on rising edge
//  RST        in   1        synchronous reset, active-high
//  IN_VALID   in   1        operands/OP presented
//  IN_READY   out  1        unit idle, accepts on IN_VALID&IN_READY
//  A, B       in   BITS     operands (two's complement for O/S)
//  OP         in   5        opcode (table below)
//  CLR_FLAGS  in   1        clears O,C,S,Z next edge
//  RESU       out  BITS     result (low half for MUL)
//  RESU_HI    out  BITS     MUL high half; 0 for all other ops
//  OUT_VALID  out  1        one-cycle pulse: RESU/RESU_HI/ERR/flags valid
//  ERR        out  1        with OUT_VALID: OP undefined
//  O,C,S,Z    out  1        registered overflow, carry, sign, zero flags
// BEHAVIOUR
//  Reset: state IDLE; RESU, RESU_HI, OUT_VALID, ERR, O, C, S, Z = 0; IN_READY=1 the cycle after.
//  Opcodes: 00000 ADD A+B | 00001 ADDC A+B+C | 00010 SUB A+~B+1 | 00011 SUBC A+~B+C
//   00100 INC A+1 | 00101 DEC A-1 | 01000 AND | 01001 OR | 01010 XOR | 01011 NOT A
//   01100 PASS A | 10000 SHL A,1 | 10001 SHR A,1 logical | 10010 SAR A,1 | 11000 MUL unsigned.
//   All others undefined.
//  FSM: IDLE -accept, OP!=MUL-> EXEC -> DONE -> IDLE.
//   IDLE -accept, MUL-> MULT (BITS iterations) -> DONE -> IDLE.
//   IN_READY = (state==IDLE); OUT_VALID = (state==DONE).
//  Accept at edge k latches A, B, OP and current C flag; later changes on inputs are ignored.
//  Latency: non-MUL OUT_VALID in the cycle after edge k+1.
//   MUL OUT_VALID in the cycle after edge k+BITS.
//   Next accept is possible only when the unit returns to IDLE.
//  Arithmetic: BITS+1-bit sum.
//   C = carry out (SUB/SUBC/DEC: 1 = no borrow).
//   O = signed overflow: operand signs equal and result sign differs.
//  Logic/PASS/NOT: O=0, C=0.
//  Shifts: C = bit shifted out; O=0, except SHL where O = A[BITS-1]^A[BITS-2].
//  MUL: {RESU_HI,RESU} = A*B over 2*BITS bits; C=O=(RESU_HI!=0); Z over the full product.
//  Non-MUL: S = RESU[BITS-1], Z = (RESU==0); RESU_HI = 0.
//  Flags and RESU are updated only on the DONE-entry edge of a defined op.
//  Undefined OP, or MUL with MUL_EN=0: EXEC path, RESU=0, ERR=1 with OUT_VALID.
//   O/C/S/Z are unchanged.
//  CLR_FLAGS on the same edge as a flag update: the clear wins, flags = 0.
//  RST mid-EXEC/MULT/DONE: abort; no OUT_VALID; all outputs at reset values.
//  IN_VALID while IN_READY=0: ignored, no queueing.
//  Wrap-around: INC 0xFF -> 0x00 with C=1, Z=1; DEC 0x00 -> 0xFF with C=0, S=1.
// TESTING (BITS=8)
//  1. ADD A=7F B=01, accept edge k -> OUT_VALID after k+1, RESU=80, O=1 C=0 S=1 Z=0, RESU_HI=00.
//  2. ADD FF+01 -> RESU=00, C=1, Z=1.
//     Then ADDC 00+00 -> RESU=01, C=0, Z=0 (carry chaining through the latched C).
//  3. SUB 05-05 -> RESU=00, C=1, Z=1, O=0.
//     SUB 00-01 -> RESU=FF, C=0, S=1.
//  4. MUL 10*20 -> OUT_VALID 8 cycles after accept; RESU=00, RESU_HI=02, C=O=1, Z=0.
//     IN_VALID held high meanwhile -> IN_READY=0, no second accept.
//  5. MUL FF*FF, RST asserted 4 cycles after accept -> no OUT_VALID; all outputs 0.
//     IN_READY=1 next cycle; fresh ADD 01+01 -> 02.
//  6. Set flags via ADD FF+01 (C=1 Z=1), then OP=00111 -> ERR=1, RESU=00, C=1 Z=1 retained.
//     Then CLR_FLAGS on the DONE edge of AND FF,0F -> RESU=0F, O=C=S=Z=0.

Source files
------------

// File: rtl/ula_seq_flags.sv
// Sequential ALU: add/sub/logic/shift in one execute cycle, shift-add multiply over BITS cycles.
// Registered result and O/C/S/Z flags; single outstanding operation, IN_READY only when idle.
module ula_seq_flags #(
    parameter int BITS   = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [4:0]      OP,
    input  logic            CLR_FLAGS,
    output logic [BITS-1:0] RESU,
    output logic [BITS-1:0] RESU_HI,
    output logic            OUT_VALID,
    output logic            ERR,
    output logic            O,
    output logic            C,
    output logic            S,
    output logic            Z
);
    localparam int CW = $clog2(BITS);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDC = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SUBC = 5'b00011;
    localparam logic [4:0] OP_INC  = 5'b00100;
    localparam logic [4:0] OP_DEC  = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_XOR  = 5'b01010;
    localparam logic [4:0] OP_NOT  = 5'b01011;
    localparam logic [4:0] OP_PASS = 5'b01100;
    localparam logic [4:0] OP_SHL  = 5'b10000;
    localparam logic [4:0] OP_SHR  = 5'b10001;
    localparam logic [4:0] OP_SAR  = 5'b10010;
    localparam logic [4:0] OP_MUL  = 5'b11000;

    typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;

    state_t            state, state_nx;
    logic [BITS-1:0]   a_q, b_q;
    logic [4:0]        op_q;
    logic              c_q;
    logic              err_q;
    logic [CW-1:0]     cnt;
    logic [2*BITS-1:0] prod, prod_nx;
    logic [BITS:0]     mul_add;

    logic [BITS-1:0]   bop, res;
    logic [BITS:0]     sum;
    logic              cin, f_o, f_c, defined, is_arith;

    logic              mul_last;
    logic [BITS-1:0]   mul_hi;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (IN_VALID) state_nx = (MUL_EN && OP == OP_MUL) ? MULT : EXEC;
            EXEC: state_nx = DONE;
            MULT: if (mul_last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);
    assign ERR       = (state == DONE) && err_q;

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    assign mul_add  = {1'b0, prod[2*BITS-1:BITS]} + (prod[0] ? {1'b0, a_q} : {(BITS+1){1'b0}});
    assign prod_nx  = {mul_add, prod[BITS-1:1]};
    assign mul_last = (cnt == CW'(BITS-1));
    assign mul_hi   = prod_nx[2*BITS-1:BITS];

    always_comb begin
        bop      = '0;
        cin      = 1'b0;
        res      = '0;
        f_o      = 1'b0;
        f_c      = 1'b0;
        defined  = 1'b1;
        is_arith = 1'b0;
        case (op_q)
            OP_ADD:  begin is_arith = 1'b1; bop = b_q; end
            OP_ADDC: begin is_arith = 1'b1; bop = b_q;  cin = c_q;  end
            OP_SUB:  begin is_arith = 1'b1; bop = ~b_q; cin = 1'b1; end
            OP_SUBC: begin is_arith = 1'b1; bop = ~b_q; cin = c_q;  end
            OP_INC:  begin is_arith = 1'b1; bop = '0;   cin = 1'b1; end
            OP_DEC:  begin is_arith = 1'b1; bop = '1;   end
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~a_q;
            OP_PASS: res = a_q;
            OP_SHL:  begin
                res = {a_q[BITS-2:0], 1'b0};
                f_c = a_q[BITS-1];
                f_o = a_q[BITS-1] ^ a_q[BITS-2];
            end
            OP_SHR:  begin res = {1'b0, a_q[BITS-1:1]};        f_c = a_q[0]; end
            OP_SAR:  begin res = {a_q[BITS-1], a_q[BITS-1:1]}; f_c = a_q[0]; end
            default: defined = 1'b0;
        endcase
        sum = {1'b0, a_q} + {1'b0, bop} + {{BITS{1'b0}}, cin};
        if (is_arith) begin
            res = sum[BITS-1:0];
            f_c = sum[BITS];
            f_o = (a_q[BITS-1] == bop[BITS-1]) && (sum[BITS-1] != a_q[BITS-1]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            prod    <= '0;
            RESU    <= '0;
            RESU_HI <= '0;
            O       <= 1'b0;
            C       <= 1'b0;
            S       <= 1'b0;
            Z       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (IN_VALID) begin
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= OP;
                    c_q   <= C;
                    err_q <= 1'b0;
                    cnt   <= '0;
                    prod  <= {{BITS{1'b0}}, B};
                end
                EXEC: begin
                    RESU_HI <= '0;
                    if (defined) begin
                        RESU <= res;
                        O    <= f_o;
                        C    <= f_c;
                        S    <= res[BITS-1];
                        Z    <= (res == '0);
                    end else begin
                        RESU  <= '0;
                        err_q <= 1'b1;
                    end
                end
                MULT: begin
                    prod <= prod_nx;
                    cnt  <= cnt + CW'(1);
                    if (mul_last) begin
                        RESU    <= prod_nx[BITS-1:0];
                        RESU_HI <= mul_hi;
                        O       <= (mul_hi != '0);
                        C       <= (mul_hi != '0);
                        S       <= mul_hi[BITS-1];
                        Z       <= (prod_nx == '0);
                    end
                end
                default: ;
            endcase
            // A clear overrides any flag update landing on the same edge.
            if (CLR_FLAGS) begin
                O <= 1'b0;
                C <= 1'b0;
                S <= 1'b0;
                Z <= 1'b0;
            end
        end
    end
endmodule
